s832_resp_compactor: RTL and testbench
======================================

S832_RESP_COMPACTOR -- requirements
Module: s832_resp_compactor

Interface
REQ-001 SHALL have parameter SEED, default 19'h00001, MISR value loaded at start of each run.
REQ-002 SHALL have port CK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port START  input  1  begin a compaction run; sampled only in IDLE.
REQ-005 SHALL have port ABORT  input  1  cancel the run in progress.
REQ-006 SHALL have port NCYC  input  8  number of qualified response cycles to compact; latched on accepted START.
REQ-007 SHALL have port RESP  input  19  s832 outputs, bit order {G327,G325,G322,G315,G312,G310,G302,G300,G298,G296,G292,G290,G288,G55,G53,G49,G47,G45,G43} (MSB first).
REQ-008 SHALL have port RESP_VLD  input  1  RESP qualifier; only qualified cycles are compacted and counted.
REQ-009 SHALL have port RD_RDY  input  1  consumer accepts the signature.
REQ-010 SHALL have port BUSY  output  1  high in RUN.
REQ-011 SHALL have port SIG_VLD  output  1  high in DONE.
REQ-012 SHALL have port SIG  output  19  MISR signature register.
REQ-013 SHALL have port CNT  output  8  qualified cycles compacted in the current or last run.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE, with all outputs registered.
REQ-015 IDLE: START=1 and ABORT=0 -> latch NCYC, SIG<=SEED, CNT<=0; next state RUN, or DONE if NCYC==0.
REQ-016 RUN: each cycle with RESP_VLD=1 -> SIG<=misr(SIG,RESP) and CNT<=CNT+1; when CNT+1 equals the latched NCYC, next state DONE.
REQ-017 RUN with RESP_VLD=0 -> SIG and CNT hold, state holds.
REQ-018 MISR polynomial SHALL be x^19+x^5+x^2+x+1.
REQ-019 MISR next-state: n[0]=RESP[0]^s[18]; n[i]=RESP[i]^s[i-1] for i=3,4,6..18; n[i]=RESP[i]^s[i-1]^s[18] for i=1,2,5.
REQ-020 DONE: SIG_VLD=1 and SIG stable; RD_RDY=1 -> IDLE next cycle, SIG_VLD deasserted on that edge.
REQ-021 SIG and CNT SHALL retain their values in IDLE after DONE or ABORT until the next accepted START.
REQ-022 ABORT=1 in RUN or DONE -> IDLE next cycle; SIG and CNT freeze at current values; a same-cycle RESP_VLD is not compacted.
REQ-023 ABORT and START both high in IDLE -> ABORT wins; state stays IDLE, no load.
REQ-024 START outside IDLE SHALL be ignored, and NCYC changes after latching SHALL have no effect.
REQ-025 NCYC=255 SHALL compact exactly 255 cycles, and CNT SHALL never wrap within a run.
REQ-026 BUSY and SIG_VLD SHALL never be high simultaneously.
REQ-027 Latency: START edge -> BUSY=1 after 1 cycle; last qualified RESP edge -> SIG_VLD=1 after 1 cycle.

Reset
REQ-028 RN=0 SHALL immediately force IDLE, BUSY=0, SIG_VLD=0, SIG=SEED and CNT=0, independent of CK.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL discard the run; after RN rises, the first START SHALL begin a fresh run.

Verification
REQ-030 SEED=1, START with NCYC=1, RESP=0, RESP_VLD=1 -> SIG=19'h00002, CNT=1, SIG_VLD=1 one cycle after the RESP cycle.
REQ-031 SEED=19'h40000, NCYC=1, RESP=0 -> SIG=19'h00027 (feedback taps verified).
REQ-032 SEED=1, NCYC=1, RESP=19'h7FFFF -> SIG=19'h7FFFD, and holding RD_RDY=0 for 5 cycles keeps SIG_VLD=1 and SIG stable.
REQ-033 NCYC=3, RESP=0, RESP_VLD pattern 1,0,0,1,1 -> SIG=19'h00008 after the fifth cycle, CNT=3, BUSY high for 5 cycles.
REQ-034 NCYC=0 -> DONE one cycle after START with SIG=SEED and CNT=0, and START+ABORT in IDLE -> no state change.
REQ-035 RN pulsed low mid-RUN (CNT=2) -> outputs return to reset values asynchronously, and a new START with NCYC=1, RESP=0 gives SIG=19'h00002.

Source files
------------

// File: rtl/s832_resp_compactor.sv
// s832_resp_compactor
// Compacts qualified s832 response words into a 19-bit MISR signature.
// The MISR uses the polynomial x^19+x^5+x^2+x+1.
//
// Run control, from IDLE:
//   - START (without ABORT) latches NCYC, loads SIG with SEED and clears CNT.
//   - RUN then compacts one RESP word on each RESP_VLD cycle.
//   - The run moves to DONE once CNT reaches the latched NCYC.
//   - DONE presents SIG until RD_RDY, or until ABORT.
//
// Output handshake: SIG is valid while SIG_VLD is high. The consumer takes it
// on the rising edge where SIG_VLD and RD_RDY are both high. SIG_VLD drops on
// that same edge.
//
// SIG and CNT keep their last values through IDLE. They change only on the
// next accepted START, or on reset.
module s832_resp_compactor #(
  parameter logic [18:0] SEED = 19'h00001
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        START,
  input  logic        ABORT,
  input  logic [7:0]  NCYC,
  input  logic [18:0] RESP,
  input  logic        RESP_VLD,
  input  logic        RD_RDY,
  output logic        BUSY,
  output logic        SIG_VLD,
  output logic [18:0] SIG,
  output logic [7:0]  CNT,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_ncyc;
  logic [18:0] r_sig;
  logic [7:0]  r_cnt;
  logic        r_busy;
  logic        r_sig_vld;

  logic [18:0] w_misr;
  logic [7:0]  w_cnt_inc;
  logic        w_last;

  // MISR next state: shift up, fold s[18] back into taps 0, 1, 2 and 5, then XOR in RESP.
  always_comb begin
    w_misr     = '0;
    w_misr[0]  = RESP[0] ^ r_sig[18];
    w_misr[1]  = RESP[1] ^ r_sig[0] ^ r_sig[18];
    w_misr[2]  = RESP[2] ^ r_sig[1] ^ r_sig[18];
    w_misr[3]  = RESP[3] ^ r_sig[2];
    w_misr[4]  = RESP[4] ^ r_sig[3];
    w_misr[5]  = RESP[5] ^ r_sig[4] ^ r_sig[18];
    for (int i = 6; i < 19; i++) begin
      w_misr[i] = RESP[i] ^ r_sig[i-1];
    end
  end

  // Count increment and last-word detect.
  // RUN is only entered with a latched NCYC of at least 1, and it is left as
  // soon as the count reaches NCYC. So r_cnt never exceeds 254 while in RUN,
  // and the 8-bit increment cannot wrap.
  always_comb begin
    w_cnt_inc = r_cnt + 8'd1;
    w_last    = (w_cnt_inc == r_ncyc);
  end

  // Control FSM: state, registered BUSY/SIG_VLD, signature and count.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state   <= ST_IDLE;
      r_ncyc    <= '0;
      r_sig     <= SEED;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_sig_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // ABORT takes priority over START here: nothing is loaded.
          if (START && !ABORT) begin
            r_ncyc <= NCYC;
            r_sig  <= SEED;
            r_cnt  <= '0;
            if (NCYC == 8'd0) begin
              r_state   <= ST_DONE;
              r_sig_vld <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // On ABORT, a RESP_VLD in the same cycle is dropped and SIG/CNT freeze.
          if (ABORT) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (RESP_VLD) begin
            r_sig <= w_misr;
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              r_state   <= ST_DONE;
              r_busy    <= 1'b0;
              r_sig_vld <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (ABORT || RD_RDY) begin
            r_state   <= ST_IDLE;
            r_sig_vld <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_sig_vld <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign SIG_VLD   = r_sig_vld;
  assign SIG       = r_sig;
  assign CNT       = r_cnt;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_s832_resp_compactor.sv
// Testbench for s832_resp_compactor.
// The stimulus tasks compute each expected {SIG,CNT} with an independent
// polynomial model and push it to exp_q. The result is popped and compared
// once the DUT raises SIG_VLD.
module tb_s832_resp_compactor;

  localparam logic [18:0] SEED = 19'h00001;

  // ---------------------------------------------------------------- clock/reset
  logic        CK = 1'b0;
  logic        RN;
  logic        START;
  logic        ABORT;
  logic [7:0]  NCYC;
  logic [18:0] RESP;
  logic        RESP_VLD;
  logic        RD_RDY;
  logic        BUSY;
  logic        SIG_VLD;
  logic [18:0] SIG;
  logic [7:0]  CNT;
  logic [1:0]  DBG_STATE;

  always #5 CK = ~CK;

  s832_resp_compactor #(.SEED(SEED)) dut (
    .CK(CK), .RN(RN), .START(START), .ABORT(ABORT), .NCYC(NCYC),
    .RESP(RESP), .RESP_VLD(RESP_VLD), .RD_RDY(RD_RDY),
    .BUSY(BUSY), .SIG_VLD(SIG_VLD), .SIG(SIG), .CNT(CNT),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [26:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference MISR: Galois shift with the feedback mask for taps x^5, x^2, x^1, x^0.
  function automatic logic [18:0] misr_model(input logic [18:0] s, input logic [18:0] r);
    logic [18:0] n;
    n = {s[17:0], 1'b0};
    if (s[18]) n = n ^ 19'h00027;
    return n ^ r;
  endfunction

  // BUSY and SIG_VLD must never be high together.
  always @(negedge CK) begin
    if (RN) check("busy_sigvld_excl", 32'(BUSY & SIG_VLD), 32'd0);
  end

  // ---------------------------------------------------------------- drivers
  // One full run.
  //   mode: 0 = RESP_VLD always high
  //         1 = RESP_VLD taken from pattern bits
  //         2 = random RESP_VLD and random RESP
  // After DONE, RD_RDY is held low for `hold` cycles before the signature is read.
  task automatic do_run(input logic [7:0] ncyc, input int mode, input logic [31:0] pat,
                        input logic [18:0] fixed_resp, input int hold);
    logic [18:0] m_sig;
    logic [7:0]  m_cnt;
    logic [18:0] r;
    logic        v;
    logic [26:0] e;
    int          idx;
    int          busy_cyc;
    int          w;
    m_sig = SEED; m_cnt = 8'd0; idx = 0; busy_cyc = 0;
    START = 1'b1; NCYC = ncyc; ABORT = 1'b0; RESP_VLD = 1'b0; RD_RDY = 1'b0;
    @(negedge CK);
    START = 1'b0;
    NCYC  = 8'($urandom_range(0, 255));
    check("start_busy", 32'(BUSY), 32'(ncyc != 8'd0));
    check("start_sigvld", 32'(SIG_VLD), 32'(ncyc == 8'd0));
    while (m_cnt != ncyc && idx < 2000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? pat[idx % 32] : 1'($urandom_range(0, 1));
      r = (mode == 2) ? 19'($urandom) : fixed_resp;
      RESP_VLD = v; RESP = r;
      START = 1'($urandom_range(0, 1));
      NCYC  = 8'($urandom_range(0, 255));
      if (BUSY) busy_cyc++;
      if (v) begin
        m_sig = misr_model(m_sig, r);
        m_cnt = m_cnt + 8'd1;
      end
      idx++;
      @(negedge CK);
      check("run_busy", 32'(BUSY), 32'(m_cnt != ncyc));
      check("run_sigvld", 32'(SIG_VLD), 32'(m_cnt == ncyc));
    end
    RESP_VLD = 1'b0; START = 1'b0;
    if (ncyc != 8'd0) check("busy_cycles", 32'(busy_cyc), 32'(idx));
    exp_q.push_back({m_sig, m_cnt});
    w = 0;
    while (!SIG_VLD && w < 4) begin
      @(negedge CK);
      w++;
    end
    check("sigvld_seen", 32'(SIG_VLD), 32'd1);
    e = exp_q.pop_front();
    check("sig", 32'(SIG), 32'(e[26:8]));
    check("cnt", 32'(CNT), 32'(e[7:0]));
    for (int k = 0; k < hold; k++) begin
      START = 1'b1;
      @(negedge CK);
      check("hold_sigvld", 32'(SIG_VLD), 32'd1);
      check("hold_sig", 32'(SIG), 32'(e[26:8]));
    end
    START = 1'b0; RD_RDY = 1'b1;
    @(negedge CK);
    RD_RDY = 1'b0;
    check("ack_sigvld", 32'(SIG_VLD), 32'd0);
    check("ack_busy", 32'(BUSY), 32'd0);
    check("idle_sig", 32'(SIG), 32'(e[26:8]));
    check("idle_cnt", 32'(CNT), 32'(e[7:0]));
  endtask

  // ---------------------------------------------------------------- main
  initial begin : main
    logic [18:0] m_sig;
    logic [18:0] r;
    RN = 1'b0; START = 1'b0; ABORT = 1'b0; NCYC = 8'd0;
    RESP = '0; RESP_VLD = 1'b0; RD_RDY = 1'b0;
    repeat (2) @(negedge CK);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_sigvld", 32'(SIG_VLD), 32'd0);
    check("rst_sig", 32'(SIG), 32'(SEED));
    check("rst_cnt", 32'(CNT), 32'd0);
    check("rst_state", 32'(DBG_STATE), 32'd0);
    RN = 1'b1;
    @(negedge CK);

    // Single zero word: SIG shifts from 1 to 2.
    do_run(8'd1, 0, 32'd0, 19'h00000, 2);
    // 18 zero shifts bring SIG to 19'h40000; the 19th exercises every feedback tap (19'h00027).
    do_run(8'd19, 0, 32'd0, 19'h00000, 0);
    // All-ones word, with the signature held for 5 cycles.
    do_run(8'd1, 0, 32'd0, 19'h7FFFF, 5);
    // Qualifier pattern 1,0,0,1,1 with NCYC=3.
    do_run(8'd3, 1, 32'h0000_0019, 19'h00000, 1);
    // NCYC=0 goes straight to DONE.
    do_run(8'd0, 0, 32'd0, 19'h00000, 1);
    // Random traffic, including the largest count.
    do_run(8'd8, 2, 32'd0, 19'h00000, 1);
    do_run(8'd255, 2, 32'd0, 19'h00000, 0);

    // ABORT in RUN after 3 words; the same-cycle RESP_VLD must be dropped.
    START = 1'b1; NCYC = 8'd10;
    @(negedge CK);
    START = 1'b0;
    m_sig = SEED;
    for (int k = 0; k < 3; k++) begin
      r = 19'($urandom);
      RESP = r; RESP_VLD = 1'b1;
      m_sig = misr_model(m_sig, r);
      @(negedge CK);
    end
    ABORT = 1'b1; RESP = 19'($urandom);
    @(negedge CK);
    ABORT = 1'b0; RESP_VLD = 1'b0;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_sig", 32'(SIG), 32'(m_sig));
    check("abort_cnt", 32'(CNT), 32'd3);

    // START together with ABORT in IDLE: no load, state stays IDLE.
    START = 1'b1; ABORT = 1'b1; NCYC = 8'd4;
    @(negedge CK);
    START = 1'b0; ABORT = 1'b0;
    check("sa_busy", 32'(BUSY), 32'd0);
    check("sa_sigvld", 32'(SIG_VLD), 32'd0);
    check("sa_sig", 32'(SIG), 32'(m_sig));
    check("sa_cnt", 32'(CNT), 32'd3);
    check("sa_state", 32'(DBG_STATE), 32'd0);

    // ABORT while in DONE.
    START = 1'b1; NCYC = 8'd0;
    @(negedge CK);
    START = 1'b0;
    check("done0_sigvld", 32'(SIG_VLD), 32'd1);
    ABORT = 1'b1;
    @(negedge CK);
    ABORT = 1'b0;
    check("abort_done_sigvld", 32'(SIG_VLD), 32'd0);
    check("abort_done_sig", 32'(SIG), 32'(SEED));

    // Asynchronous reset in the middle of a run, after 2 words.
    START = 1'b1; NCYC = 8'd5;
    @(negedge CK);
    START = 1'b0;
    for (int k = 0; k < 2; k++) begin
      RESP = 19'($urandom); RESP_VLD = 1'b1;
      @(negedge CK);
    end
    RESP_VLD = 1'b0;
    check("mid_cnt", 32'(CNT), 32'd2);
    #2 RN = 1'b0;
    #1;
    check("arst_busy", 32'(BUSY), 32'd0);
    check("arst_sigvld", 32'(SIG_VLD), 32'd0);
    check("arst_sig", 32'(SIG), 32'(SEED));
    check("arst_cnt", 32'(CNT), 32'd0);
    @(negedge CK);
    RN = 1'b1;
    @(negedge CK);
    do_run(8'd1, 0, 32'd0, 19'h00000, 0);

    repeat (2) @(negedge CK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit, in case the run never reaches its end.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
